// File: rtl/cache_ctrl_pkg.sv
// Shared types and constants for the data-cache refill controller.
package cache_ctrl_pkg;

  // Controller states: idle/hit pass-through, memory read, memory write, cache fill.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_REQ = 2'd1,
    WR_REQ = 2'd2,
    FILL   = 2'd3
  } refill_state_t;

  // Clears the byte-offset bits so every memory and fill access is word aligned.
  // Wide enough for any practical address width; users slice the low bits.
  localparam logic [63:0] WORD_ALIGN_MASK = ~64'h3;

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts request cycles without an ack; flags the cycle on which the wait
// would reach TIMEOUT-1 so the controller can abort on that same edge.
module mem_timeout_counter #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST     = W'(TIMEOUT - 1);
  localparam logic [W-1:0] PRE_LAST = W'(TIMEOUT - 2);

  logic [W-1:0] count_q;

  // Cycle counter: restarts on clear, advances while waiting, saturates at TIMEOUT-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != LAST)) begin
      count_q <= count_q + 1'b1;
    end
  end

  // High when this un-acked cycle is the one that brings the count to TIMEOUT-1.
  assign expired = enable && (count_q == PRE_LAST);

endmodule

// File: rtl/cache_refill_controller.sv
// Miss handler between the CPU load/store port, the cache and data memory.
// Load hits pass through combinationally; load misses and all stores stall,
// run one req/ack memory transaction and finish with a one-cycle cache fill.
module cache_refill_controller
  import cache_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req_i,
  input  logic                  cpu_we_i,
  input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
  input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
  input  logic                  cache_hit_i,
  input  logic [DATA_WIDTH-1:0] cache_rdata_i,
  output logic                  stall_o,
  output logic                  cpu_rvalid_o,
  output logic [DATA_WIDTH-1:0] cpu_rdata_o,
  output logic                  fill_en_o,
  output logic [ADDR_WIDTH-1:0] fill_addr_o,
  output logic [DATA_WIDTH-1:0] fill_data_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  timeout_o
);

  localparam logic [ADDR_WIDTH-1:0] ALIGN = WORD_ALIGN_MASK[ADDR_WIDTH-1:0];

  refill_state_t         state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  we_q;
  logic                  aborted_q;
  logic                  timeout_q;

  logic in_req;
  logic tmo_expired;

  assign in_req = (state_q == RD_REQ) || (state_q == WR_REQ);

  // Wait counter restarts whenever no request is outstanding; an ack stops it.
  mem_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (!in_req),
    .enable (in_req && !mem_ack_i),
    .expired(tmo_expired)
  );

  // Controller FSM plus the latched address, store data and captured read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      we_q      <= 1'b0;
      aborted_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cpu_req_i && (cpu_we_i || !cache_hit_i)) begin
            addr_q    <= cpu_addr_i & ALIGN;
            we_q      <= cpu_we_i;
            aborted_q <= 1'b0;
            if (cpu_we_i) begin
              wdata_q <= cpu_wdata_i;
              state_q <= WR_REQ;
            end else begin
              state_q <= RD_REQ;
            end
          end
        end
        RD_REQ, WR_REQ: begin
          if (mem_ack_i) begin
            if (state_q == RD_REQ) rdata_q <= mem_rdata_i;
            state_q <= FILL;
          end else if (tmo_expired) begin
            // Abort: an aborted load returns zero, and the error stays set until reset.
            timeout_q <= 1'b1;
            aborted_q <= 1'b1;
            rdata_q   <= '0;
            state_q   <= FILL;
          end
        end
        FILL: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Output decode; everything is forced low while reset is asserted.
  always_comb begin
    stall_o      = 1'b0;
    cpu_rvalid_o = 1'b0;
    cpu_rdata_o  = '0;
    fill_en_o    = 1'b0;
    fill_addr_o  = '0;
    fill_data_o  = '0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (cpu_req_i) begin
            if (!cpu_we_i && cache_hit_i) begin
              cpu_rvalid_o = 1'b1;
              cpu_rdata_o  = cache_rdata_i;
            end else begin
              stall_o = 1'b1;
            end
          end
        end
        RD_REQ, WR_REQ: begin
          stall_o    = 1'b1;
          mem_req_o  = 1'b1;
          mem_we_o   = (state_q == WR_REQ);
          mem_addr_o = addr_q;
          if (state_q == WR_REQ) mem_wdata_o = wdata_q;
        end
        FILL: begin
          if (!aborted_q) begin
            fill_en_o   = 1'b1;
            fill_addr_o = addr_q;
            fill_data_o = we_q ? wdata_q : rdata_q;
          end
          if (!we_q) begin
            cpu_rvalid_o = 1'b1;
            cpu_rdata_o  = rdata_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign timeout_o = timeout_q;

endmodule
